// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin lock arbiter that lets several byte-stream
// requesters share a single uart_tx. A requester keeps the lock until the
// byte flagged as last has been fully shifted out (or the uart fails to start).
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   uart_tx_en,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_busy,
  output logic                   arb_busy,
  output logic                   tx_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   last_owner, last_owner_next;
  logic [NUM_REQ-1:0] grant_next;
  logic               last_flag, last_flag_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               tx_err_next;

  logic [IDX_W-1:0]   rr_winner;
  logic               rr_found;
  int                 rr_sum;

  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_byte;

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_byte  = req_data[{owner, 3'b000} +: 8];
  assign arb_busy    = (state != IDLE);

  // Round-robin search: first valid requester after last_owner, wrapping around.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_sum    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_sum = int'(last_owner) + i;
      if (rr_sum >= NUM_REQ) rr_sum = rr_sum - NUM_REQ;
      if (!rr_found && req_valid[IDX_W'(rr_sum)]) begin
        rr_found  = 1'b1;
        rr_winner = IDX_W'(rr_sum);
      end
    end
  end

  // Next-state and output decode; strobes only ever leave SEND.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    grant_next      = grant;
    last_owner_next = last_owner;
    last_flag_next  = last_flag;
    cnt_next        = cnt;
    tx_err_next     = 1'b0;
    req_ready       = '0;
    uart_tx_en      = 1'b0;
    uart_tx_data    = '0;

    case (state)
      IDLE: begin
        if (rr_found && !uart_tx_busy) begin
          owner_next = rr_winner;
          grant_next = ONE_HOT0 << rr_winner;
          state_next = SEND;
        end
      end

      SEND: begin
        uart_tx_data = owner_byte;
        if (owner_valid) begin
          uart_tx_en     = 1'b1;
          req_ready      = grant;
          last_flag_next = owner_last;
          cnt_next       = '0;
          state_next     = WAIT_START;
        end
      end

      WAIT_START: begin
        if (uart_tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
          if (cnt >= CNT_LIMIT) begin
            tx_err_next     = 1'b1;
            grant_next      = '0;
            last_owner_next = owner;
            state_next      = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_flag) begin
            grant_next      = '0;
            last_owner_next = owner;
            state_next      = IDLE;
          end else begin
            state_next = SEND;
          end
        end
      end

      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and lock registers; reset drops any lock in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      grant      <= '0;
      last_owner <= LAST_INIT;
      last_flag  <= 1'b0;
      cnt        <= '0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      grant      <= grant_next;
      last_owner <= last_owner_next;
      last_flag  <= last_flag_next;
      cnt        <= cnt_next;
      tx_err     <= tx_err_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios with a scoreboard of expected
// uart_tx transfers (grant + byte), a requester driver and a simple uart_tx model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 15;
  localparam int BUSY_CYC      = 4;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 uart_tx_en;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_busy;
  logic                 arb_busy;
  logic                 tx_err;

  logic                 model_busy;
  logic                 force_busy;
  logic                 model_on;
  logic [NUM_REQ-1:0]   stall;

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic [7:0]         data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_data[NUM_REQ][$];
  logic       src_last[NUM_REQ][$];

  int checks = 0;
  int errors = 0;

  assign uart_tx_busy = model_busy | force_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .arb_busy    (arb_busy),
    .tx_err      (tx_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue one byte for a requester (the driver presents it when its turn comes).
  task automatic applyStimulus(input int k, input logic [7:0] data, input logic last);
    src_data[k].push_back(data);
    src_last[k].push_back(last);
  endtask

  task automatic expectTx(input logic [NUM_REQ-1:0] gnt, input logic [7:0] data);
    exp_t e;
    e.gnt  = gnt;
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic bit allDrained();
    bit empty = 1'b1;
    for (int k = 0; k < NUM_REQ; k++)
      if (src_data[k].size() != 0) empty = 1'b0;
    return empty;
  endfunction

  task automatic waitIdle(input string name);
    int n = 0;
    while (n < 400 && !(allDrained() && exp_q.size() == 0 && !arb_busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle_timeout: got busy expected idle within 400 cycles", name);
    end
  endtask

  task automatic waitEn(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      seen = uart_tx_en;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no uart_tx_en expected a pulse within 100 cycles", name);
    end
  endtask

  task automatic waitDrained(input int k, input string name);
    int n = 0;
    while (n < 100 && src_data[k].size() != 0) begin
      @(negedge clk);
      n++;
    end
    if (src_data[k].size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got byte pending expected accepted within 100 cycles", name);
    end
  endtask

  // Requester driver: retire accepted bytes, then present each queue head.
  initial begin
    logic [NUM_REQ-1:0] taken;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      taken = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (taken[k] && src_data[k].size() != 0) begin
          void'(src_data[k].pop_front());
          void'(src_last[k].pop_front());
        end
        if (src_data[k].size() != 0 && !stall[k]) begin
          req_valid[k]         = 1'b1;
          req_data[8*k +: 8]   = src_data[k][0];
          req_last[k]          = src_last[k][0];
        end else begin
          req_valid[k]         = 1'b0;
          req_data[8*k +: 8]   = 8'h00;
          req_last[k]          = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy rises the cycle after a send strobe and lasts BUSY_CYC cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_en && model_on) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every send strobe must match the next expected transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && uart_tx_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx: got grant=0x%0h data=0x%0h expected no transfer", grant, uart_tx_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_grant", 32'(grant), 32'(e.gnt));
          checkOutput("tx_data", 32'(uart_tx_data), 32'(e.data));
          checkOutput("tx_ready", 32'(req_ready), 32'(e.gnt));
          checkOutput("tx_uart_idle", 32'(uart_tx_busy), 32'd0);
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    int pulses;
    reset      = 1'b1;
    force_busy = 1'b0;
    model_on   = 1'b1;
    stall      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_arb_busy", 32'(arb_busy), 32'd0);
    checkOutput("rst_tx_en", 32'(uart_tx_en), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_err", 32'(tx_err), 32'd0);
    reset = 1'b0;

    // Single requester, three-byte message
    applyStimulus(0, 8'h41, 1'b0); expectTx(4'b0001, 8'h41);
    applyStimulus(0, 8'h42, 1'b0); expectTx(4'b0001, 8'h42);
    applyStimulus(0, 8'h43, 1'b1); expectTx(4'b0001, 8'h43);
    waitIdle("t1");
    checkOutput("t1_end_grant", 32'(grant), 32'd0);
    checkOutput("t1_end_idle", 32'(arb_busy), 32'd0);

    // All four requesting out of reset; requester 0 comes back for a second turn
    reset = 1'b1;
    applyStimulus(0, 8'h10, 1'b1); expectTx(4'b0001, 8'h10);
    applyStimulus(1, 8'h11, 1'b1); expectTx(4'b0010, 8'h11);
    applyStimulus(2, 8'h12, 1'b1); expectTx(4'b0100, 8'h12);
    applyStimulus(3, 8'h13, 1'b1); expectTx(4'b1000, 8'h13);
    applyStimulus(0, 8'h20, 1'b1); expectTx(4'b0001, 8'h20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitIdle("t2");

    // Requester 1 holds the lock for two bytes while requester 0 waits
    applyStimulus(1, 8'hB1, 1'b0); expectTx(4'b0010, 8'hB1);
    applyStimulus(1, 8'hB2, 1'b1); expectTx(4'b0010, 8'hB2);
    applyStimulus(0, 8'hC0, 1'b1); expectTx(4'b0001, 8'hC0);
    waitIdle("t3");

    // Requester 2 stalls mid-message; lock is held in SEND
    applyStimulus(2, 8'hD0, 1'b0); expectTx(4'b0100, 8'hD0);
    waitDrained(2, "t4_first");
    stall[2] = 1'b1;
    applyStimulus(2, 8'hD1, 1'b0); expectTx(4'b0100, 8'hD1);
    applyStimulus(2, 8'hD2, 1'b1); expectTx(4'b0100, 8'hD2);
    repeat (15) @(negedge clk);
    checkOutput("t4_stall_grant", 32'(grant), 32'h4);
    checkOutput("t4_stall_busy", 32'(arb_busy), 32'd1);
    checkOutput("t4_stall_en", 32'(uart_tx_en), 32'd0);
    checkOutput("t4_stall_ready", 32'(req_ready), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t4_stall_grant_late", 32'(grant), 32'h4);
    checkOutput("t4_stall_en_late", 32'(uart_tx_en), 32'd0);
    stall[2] = 1'b0;
    waitIdle("t4");

    // uart_tx never starts: timeout after START_TIMEOUT cycles in WAIT_START
    model_on = 1'b0;
    applyStimulus(3, 8'h51, 1'b1); expectTx(4'b1000, 8'h51);
    waitEn("t5_en");
    pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (tx_err) pulses++;
      if (j == 15) begin
        checkOutput("t5_err_early", 32'(tx_err), 32'd0);
        checkOutput("t5_still_waiting", 32'(arb_busy), 32'd1);
      end
      if (j == 16) begin
        checkOutput("t5_err_pulse", 32'(tx_err), 32'd1);
        checkOutput("t5_grant_clear", 32'(grant), 32'd0);
        checkOutput("t5_idle", 32'(arb_busy), 32'd0);
      end
    end
    checkOutput("t5_pulse_count", 32'(pulses), 32'd1);
    model_on = 1'b1;

    // Reset in WAIT_DONE with uart busy; re-grant only once busy falls
    applyStimulus(0, 8'h61, 1'b0); expectTx(4'b0001, 8'h61);
    applyStimulus(0, 8'h62, 1'b1);
    waitEn("t6_en");
    repeat (2) @(negedge clk);
    checkOutput("t6_uart_busy", 32'(uart_tx_busy), 32'd1);
    checkOutput("t6_locked", 32'(grant), 32'h1);
    force_busy = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_grant", 32'(grant), 32'd0);
    checkOutput("t6_rst_busy", 32'(arb_busy), 32'd0);
    checkOutput("t6_rst_en", 32'(uart_tx_en), 32'd0);
    checkOutput("t6_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_rst_data", 32'(uart_tx_data), 32'd0);
    checkOutput("t6_rst_err", 32'(tx_err), 32'd0);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checkOutput("t6_hold_grant", 32'(grant), 32'd0);
      checkOutput("t6_hold_idle", 32'(arb_busy), 32'd0);
    end
    expectTx(4'b0001, 8'h62);
    force_busy = 1'b0;
    waitIdle("t6");
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
